oled_frame_source: RTL and testbench

Framebuffer and byte streamer that sits directly upstream of the SSD1306 SPI driver. Holds a 128x64 monochrome image as 1024 bytes in SSD1306 horizontal-addressing order (page-major, one byte = 8 vertical pixels, LSB = top row) and streams it byte-by-byte to the driver over a valid/ready handshake. Host logic updates the image through a byte write port and can fill the whole buffer with a pattern.

---
 rtl/oled_pkg.sv | 23 ++
 rtl/oled_fb_ram.sv | 35 +++
 rtl/oled_frame_source.sv | 170 +++++++++++++++++
 tb/tb_oled_frame_source.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED frame source and the SSD1306 SPI driver.
// Holds the default panel geometry, framebuffer depth/address width and the
// frame-source state encoding.
package oled_pkg;

  localparam int unsigned OLED_COLS  = 128;
  localparam int unsigned OLED_PAGES = 8;
  localparam int unsigned FB_DEPTH   = OLED_COLS * OLED_PAGES;
  localparam int unsigned FB_ADDR_W  = $clog2(FB_DEPTH);
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEAR = 3'd1;
  localparam logic [STATE_W-1:0] ST_FETCH = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd4;

  // Address width for a buffer of the given depth (at least one bit).
  function automatic int unsigned fb_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/oled_fb_ram.sv
// Simple dual-port framebuffer RAM, one write port and one synchronous
// read-first read port (1-cycle latency). Contents are not reset.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port
//   raddr_i          read address, data appears on rdata_o next cycle
//   rdata_o          registered read data (old byte on same-address write)
module oled_fb_ram
  import oled_pkg::*;
#(
  parameter int unsigned DEPTH  = FB_DEPTH,
  parameter int unsigned ADDR_W = FB_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Non-blocking read and write on the same edge gives read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/oled_frame_source.sv
// Framebuffer and byte streamer feeding the SSD1306 SPI driver. Streams the
// image in horizontal-addressing order over valid/ready, accepts host byte
// writes and can fill the whole buffer with a pattern.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data     host byte write port
//   clear_req/clear_pattern   fill request and fill byte
//   start                     one-frame trigger when CONTINUOUS=0
//   busy                      combinational, low only in IDLE
//   byte_data/byte_valid      byte offered downstream
//   byte_ready                downstream accept
//   frame_start               marks byte 0 of a frame
//   frame_done                one-cycle pulse after the last byte handshake
module oled_frame_source
  import oled_pkg::*;
#(
  parameter int unsigned COLS       = OLED_COLS,
  parameter int unsigned PAGES      = OLED_PAGES,
  parameter bit          CONTINUOUS = 1'b1,
  localparam int unsigned DEPTH     = COLS * PAGES,
  localparam int unsigned ADDR_W    = fb_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              clear_req,
  input  logic [7:0]        clear_pattern,
  input  logic              start,
  output logic              busy,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              frame_start,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic               pend_q, pend_d;
  logic [7:0]         pat_q, pat_d;
  logic [7:0]         byte_data_q, byte_data_d;
  logic               byte_valid_q, byte_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_done_q, frame_done_d;

  logic               ram_we_c;
  logic [ADDR_W-1:0]  ram_waddr_c;
  logic [7:0]         ram_wdata_c;
  logic [7:0]         ram_rdata;
  logic               wr_in_range_c;

  assign wr_in_range_c = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));

  oled_fb_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we_c),
    .waddr_i (ram_waddr_c),
    .wdata_i (ram_wdata_c),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Next-state, datapath and RAM write-port control.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    pend_d        = pend_q;
    pat_d         = pat_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = byte_valid_q;
    frame_start_d = frame_start_q;
    frame_done_d  = 1'b0;
    ram_we_c      = wr_en && wr_in_range_c;
    ram_waddr_c   = wr_addr;
    ram_wdata_c   = wr_data;

    // A pending flag that stays set through CLEAR makes repeat requests no-ops.
    if (!pend_q && clear_req) begin
      pend_d = 1'b1;
      pat_d  = clear_pattern;
    end

    case (state_q)
      ST_IDLE: begin
        // A request arriving in IDLE is already latched; start the fill now.
        if (pend_q || clear_req) begin
          state_d = ST_CLEAR;
        end else if (CONTINUOUS || start) begin
          state_d = ST_FETCH;
        end
      end
      ST_CLEAR: begin
        // rd_ptr is zero at every frame boundary, so it doubles as fill pointer.
        ram_we_c    = 1'b1;
        ram_waddr_c = rd_ptr_q;
        ram_wdata_c = pat_q;
        if (rd_ptr_q == LAST_ADDR) begin
          rd_ptr_d = '0;
          pend_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        byte_data_d   = ram_rdata;
        byte_valid_d  = 1'b1;
        frame_start_d = (rd_ptr_q == '0);
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (byte_ready) begin
          byte_valid_d  = 1'b0;
          frame_start_d = 1'b0;
          if (rd_ptr_q != LAST_ADDR) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            state_d  = ST_FETCH;
          end else begin
            rd_ptr_d     = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rd_ptr_q      <= '0;
      pend_q        <= 1'b0;
      pat_q         <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      pend_q        <= pend_d;
      pat_q         <= pat_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_oled_frame_source.sv
// Bench for oled_frame_source: instance 0 runs CONTINUOUS=1, instance 1 runs
// CONTINUOUS=0. A per-instance image/scoreboard model predicts every accepted
// byte, frame_start, frame_done and hold stability; directed sequences add
// literal expectations.
module tb_oled_frame_source;

  localparam int N = 1024;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst           [2];
  logic       wr_en         [2];
  logic [9:0] wr_addr       [2];
  logic [7:0] wr_data       [2];
  logic       clear_req     [2];
  logic [7:0] clear_pattern [2];
  logic       start         [2];
  logic       busy          [2];
  logic [7:0] bd            [2];
  logic       bv            [2];
  logic       rdy           [2];
  logic       fs            [2];
  logic       fd            [2];

  oled_frame_source #(.COLS(128), .PAGES(8), .CONTINUOUS(1'b1)) u_cont (
    .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .clear_req(clear_req[0]),
    .clear_pattern(clear_pattern[0]), .start(start[0]), .busy(busy[0]),
    .byte_data(bd[0]), .byte_valid(bv[0]), .byte_ready(rdy[0]),
    .frame_start(fs[0]), .frame_done(fd[0])
  );

  oled_frame_source #(.COLS(128), .PAGES(8), .CONTINUOUS(1'b0)) u_one (
    .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .clear_req(clear_req[1]),
    .clear_pattern(clear_pattern[1]), .start(start[1]), .busy(busy[1]),
    .byte_data(bd[1]), .byte_valid(bv[1]), .byte_ready(rdy[1]),
    .frame_start(fs[1]), .frame_done(fd[1])
  );

  // Model state
  logic [7:0] mem      [2][N];
  logic [7:0] seen     [2][N];
  int         exp_idx  [2];
  int         frames   [2];
  bit         hold     [2];
  logic [7:0] hold_d   [2];
  logic       hold_fs  [2];
  bit         done_due [2];
  bit         pend_clr [2];
  logic [7:0] pend_pat [2];
  int         last_acc [2];
  int         gap      [2];
  int         f0_cyc   [2];
  int         fper     [2];
  int         cyc;
  int         errors;
  int         checks;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle comparison of one instance against the model.
  task automatic mon(input int u);
    if (rst[u]) begin
      exp_idx[u]  = 0;
      hold[u]     = 0;
      done_due[u] = 0;
      return;
    end
    chk($sformatf("frame_done[%0d]", u), int'(fd[u]), int'(done_due[u]));
    done_due[u] = 0;
    if (hold[u]) begin
      chk($sformatf("hold_valid[%0d]", u), int'(bv[u]), 1);
      chk($sformatf("hold_data[%0d]", u), int'(bd[u]), int'(hold_d[u]));
      chk($sformatf("hold_fs[%0d]", u), int'(fs[u]), int'(hold_fs[u]));
    end
    if (!bv[u]) chk($sformatf("fs_without_valid[%0d]", u), int'(fs[u]), 0);
    if (bv[u] && rdy[u]) begin
      chk($sformatf("byte_data[%0d] idx %0d", u, exp_idx[u]), int'(bd[u]),
          int'(mem[u][exp_idx[u]]));
      chk($sformatf("frame_start[%0d] idx %0d", u, exp_idx[u]), int'(fs[u]),
          int'(exp_idx[u] == 0));
      seen[u][exp_idx[u]] = bd[u];
      gap[u]      = cyc - last_acc[u];
      last_acc[u] = cyc;
      if (exp_idx[u] == 0) begin
        fper[u]   = cyc - f0_cyc[u];
        f0_cyc[u] = cyc;
      end
      if (exp_idx[u] == N - 1) begin
        exp_idx[u]  = 0;
        done_due[u] = 1;
        frames[u]++;
        if (pend_clr[u]) begin
          for (int i = 0; i < N; i++) mem[u][i] = pend_pat[u];
          pend_clr[u] = 0;
        end
      end else begin
        exp_idx[u]++;
      end
    end
    hold[u]    = bv[u] && !rdy[u];
    hold_d[u]  = bd[u];
    hold_fs[u] = fs[u];
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) mon(u);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input int u, input int idx, input string nm);
    int n = 0;
    while (exp_idx[u] != idx && n < 20000) begin step(); n++; end
    chk(nm, int'(n < 20000), 1);
  endtask

  task automatic wait_frames(input int u, input int f, input string nm);
    int n = 0;
    while (frames[u] < f && n < 20000) begin step(); n++; end
    chk(nm, int'(n < 20000), 1);
  endtask

  task automatic wait_busy(input int u, input logic val, input string nm);
    int n = 0;
    while (busy[u] !== val && n < 5000) begin step(); n++; end
    chk(nm, int'(n < 5000), 1);
  endtask

  task automatic host_write(input int u, input int a, input logic [7:0] d);
    wr_en[u] = 1'b1; wr_addr[u] = 10'(a); wr_data[u] = d;
    step();
    wr_en[u] = 1'b0;
  endtask

  // Issue a clear while idle and count busy cycles until it ends.
  task automatic idle_clear(input int u, input logic [7:0] pat, input string nm);
    int n = 0;
    int k = 0;
    clear_req[u] = 1'b1; clear_pattern[u] = pat;
    step();
    clear_req[u] = 1'b0;
    while (k < 3000) begin
      @(negedge clk);
      if (busy[u]) n++;
      else if (n > 0) break;
      k++;
    end
    chk(nm, n, 1024);
    for (int i = 0; i < N; i++) mem[u][i] = pat;
    step();
  endtask

  task automatic pulse_start(input int u);
    start[u] = 1'b1;
    step();
    start[u] = 1'b0;
  endtask

  initial begin
    int f;
    errors = 0; checks = 0; cyc = 0;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; wr_en[u] = 1'b0; wr_addr[u] = '0; wr_data[u] = '0;
      clear_req[u] = 1'b0; clear_pattern[u] = '0; start[u] = 1'b0; rdy[u] = 1'b1;
      exp_idx[u] = 0; frames[u] = 0; hold[u] = 0; done_due[u] = 0;
      pend_clr[u] = 0; pend_pat[u] = '0; last_acc[u] = 0; gap[u] = 0;
      f0_cyc[u] = 0; fper[u] = 0;
      for (int i = 0; i < N; i++) begin mem[u][i] = '0; seen[u][i] = '0; end
    end
    repeat (3) step();

    // Preload instance 0 with addr[7:0] while held in reset.
    for (int i = 0; i < N; i++) begin
      mem[0][i] = 8'(i);
      host_write(0, i, 8'(i));
    end

    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset_valid[%0d]", u), int'(bv[u]), 0);
      chk($sformatf("reset_data[%0d]", u), int'(bd[u]), 0);
      chk($sformatf("reset_fs[%0d]", u), int'(fs[u]), 0);
      chk($sformatf("reset_fd[%0d]", u), int'(fd[u]), 0);
      chk($sformatf("reset_busy[%0d]", u), int'(busy[u]), 0);
    end
    step();
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Continuous streaming, ready tied high.
    wait_frames(0, 1, "timeout_frame1");
    chk("frame1_byte5", int'(seen[0][5]), 8'h05);
    chk("frame1_byte300", int'(seen[0][300]), 8'h2C);
    chk("frame1_byte1023", int'(seen[0][1023]), 8'hFF);
    chk("byte_period", gap[0], 3);
    wait_idx(0, 1, "timeout_frame2_start");
    chk("frame_period", fper[0], 3073);
    wait_frames(0, 2, "timeout_frame2");

    // Random backpressure for a whole frame.
    begin
      int n = 0;
      while (frames[0] < 3 && n < 20000) begin
        rdy[0] = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      chk("timeout_random_frame", int'(n < 20000), 1);
    end
    rdy[0] = 1'b1;

    // Host writes during streaming.
    wait_idx(0, 100, "timeout_idx100");
    mem[0][700] = 8'h3C;
    host_write(0, 700, 8'h3C);
    wait_idx(0, 800, "timeout_idx800");
    mem[0][700] = 8'hA5;
    host_write(0, 700, 8'hA5);
    f = frames[0];
    wait_frames(0, f + 1, "timeout_write_frame");
    chk("early_write_current_frame", int'(seen[0][700]), 8'h3C);
    wait_idx(0, 701, "timeout_idx701");
    chk("late_write_next_frame", int'(seen[0][700]), 8'hA5);

    // Reset while holding byte 300.
    wait_idx(0, 300, "timeout_idx300");
    rdy[0] = 1'b0;
    begin
      int n = 0;
      while (!bv[0] && n < 10) begin step(); n++; end
      chk("timeout_valid300", int'(n < 10), 1);
    end
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(bv[0]), 0);
    chk("rst_data", int'(bd[0]), 0);
    chk("rst_fs", int'(fs[0]), 0);
    chk("rst_fd", int'(fd[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    step();
    rdy[0] = 1'b1;
    f = frames[0];
    wait_idx(0, 400, "timeout_after_rst");
    chk("after_rst_byte0", int'(seen[0][0]), 8'h00);
    chk("after_rst_byte299", int'(seen[0][299]), 8'h2B);
    wait_frames(0, f + 1, "timeout_after_rst_frame");
    chk("after_rst_byte700", int'(seen[0][700]), 8'hA5);

    // One-shot instance: clear to FF then one frame.
    idle_clear(1, 8'hFF, "clear_ff_busy_cycles");
    pulse_start(1);
    wait_frames(1, 1, "timeout_ff_frame");
    chk("ff_byte0", int'(seen[1][0]), 8'hFF);
    chk("ff_byte1023", int'(seen[1][1023]), 8'hFF);
    repeat (6) step();
    @(negedge clk);
    chk("oneshot_idle_busy", int'(busy[1]), 0);
    chk("oneshot_idle_valid", int'(bv[1]), 0);
    step();

    // Clear deferred to the frame boundary.
    idle_clear(1, 8'hAA, "clear_aa_busy_cycles");
    pulse_start(1);
    wait_idx(1, 500, "timeout_idx500");
    clear_req[1] = 1'b1; clear_pattern[1] = 8'h00;
    pend_clr[1] = 1; pend_pat[1] = 8'h00;
    step();
    clear_req[1] = 1'b0;
    wait_frames(1, 2, "timeout_aa_frame");
    chk("aa_byte600", int'(seen[1][600]), 8'hAA);
    chk("aa_byte1023", int'(seen[1][1023]), 8'hAA);
    wait_busy(1, 1'b1, "timeout_deferred_clear");
    repeat (1000) step();
    host_write(1, 0, 8'h55);
    @(negedge clk);
    chk("still_clearing", int'(busy[1]), 1);
    step();
    wait_busy(1, 1'b0, "timeout_clear_end");
    pulse_start(1);
    wait_frames(1, 3, "timeout_zero_frame");
    chk("zero_byte0", int'(seen[1][0]), 8'h00);
    chk("zero_byte10", int'(seen[1][10]), 8'h00);
    chk("zero_byte1023", int'(seen[1][1023]), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
